// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// State encodings, strobe polarities and the instruction address width.
package pipe_ctrl_pkg;

  // Width of an instruction address; the redirect target reuses it.
  localparam int INST_ADDR_W = 32;

  // Strobe polarities seen by the pc / pc_id / id_ex registers.
  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;
  localparam logic JUMP_ENABLE  = 1'b1;
  localparam logic JUMP_DISABLE = 1'b0;

  // Controller FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    PIPE_ST_RUN   = 2'd0,
    PIPE_ST_REDIR = 2'd1,
    PIPE_ST_DIV   = 2'd2
  } pipe_st_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard controller signal bundle.
// Handshake: there is no valid/ready pair here; every request input is
// sampled in the cycle it is high, and every strobe output is valid in the
// same cycle (combinational from the inputs plus registered state).
// state_dbg exposes the controller FSM state for observation.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                   jump_req_i;
  logic [INST_ADDR_W-1:0] jump_addr_i;
  logic                   div_start_i;
  logic                   ex_is_load_i;
  logic [4:0]             ex_rd_i;
  logic [4:0]             id_rs1_i;
  logic [4:0]             id_rs2_i;
  logic                   id_rs1_re_i;
  logic                   id_rs2_re_i;
  logic                   bus_wait_i;

  logic                   hold_pc_o;
  logic                   hold_if_id_o;
  logic                   flush_if_id_o;
  logic                   flush_id_ex_o;
  logic                   hold_ex_o;
  logic                   jump_ena_o;
  logic [INST_ADDR_W-1:0] jump_addr_o;
  logic                   div_done_o;
  pipe_st_e               state_dbg;

  // Pipeline side: raises requests, consumes strobes.
  modport master (
    output jump_req_i, jump_addr_i, div_start_i, ex_is_load_i, ex_rd_i,
           id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i, bus_wait_i,
    input  hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, hold_ex_o,
           jump_ena_o, jump_addr_o, div_done_o, state_dbg
  );

  // Controller side.
  modport slave (
    input  jump_req_i, jump_addr_i, div_start_i, ex_is_load_i, ex_rd_i,
           id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i, bus_wait_i,
    output hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, hold_ex_o,
           jump_ena_o, jump_addr_o, div_done_o, state_dbg
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: purely combinational, kept separate so the
// same register-match logic can be reused by the forwarding unit.
module pipe_ctrl_hazard_detect (
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_re,
  input  logic       id_rs2_re,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // A source only counts when it is actually read; x0 never carries a hazard.
  always_comb begin
    rs1_hit  = id_rs1_re && (id_rs1 == ex_rd);
    rs2_hit  = id_rs2_re && (id_rs2 == ex_rd);
    load_use = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: arbitrates jump redirects, the
// fixed-latency divider, load-use stalls and fetch wait, and produces the
// hold/flush strobes for pc, IF/ID and ID/EX.
// Optional build macro PIPE_STALL_CNT_EN adds stall/flush cycle counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic        clk_100MHz,
  input  logic        arst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cycles_o
`endif
);

  // The start cycle is the first hold cycle, so DIV covers the remaining ones.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pipe_st_e               state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic                   load_use;

  logic                   hold_pc;
  logic                   hold_if_id;
  logic                   flush_if_id;
  logic                   flush_id_ex;
  logic                   hold_ex;
  logic                   jump_ena;
  logic [INST_ADDR_W-1:0] jump_addr;
  logic                   div_done;

  pipe_ctrl_hazard_detect u_hazard (
    .ex_is_load (bus.ex_is_load_i),
    .ex_rd      (bus.ex_rd_i),
    .id_rs1     (bus.id_rs1_i),
    .id_rs2     (bus.id_rs2_i),
    .id_rs1_re  (bus.id_rs1_re_i),
    .id_rs2_re  (bus.id_rs2_re_i),
    .load_use   (load_use)
  );

  // State, divide counter and latched redirect target.
  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state_q <= PIPE_ST_RUN;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and strobe decode; everything is forced low while in reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    hold_pc     = HOLD_DISABLE;
    hold_if_id  = HOLD_DISABLE;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    hold_ex     = HOLD_DISABLE;
    jump_ena    = JUMP_DISABLE;
    jump_addr   = addr_q;
    div_done    = 1'b0;

    case (state_q)
      PIPE_ST_RUN: begin
        if (bus.jump_req_i) begin
          // Jump wins over a same-cycle divide: the divide is younger.
          jump_ena    = JUMP_ENABLE;
          jump_addr   = bus.jump_addr_i;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          addr_d      = bus.jump_addr_i;
          state_d     = PIPE_ST_REDIR;
        end else if (bus.div_start_i) begin
          hold_pc    = HOLD_ENABLE;
          hold_if_id = HOLD_ENABLE;
          hold_ex    = HOLD_ENABLE;
          cnt_d      = DIV_LOAD;
          state_d    = PIPE_ST_DIV;
        end else if (load_use) begin
          // Keep the consumer in ID and send a bubble down to EX.
          hold_pc     = HOLD_ENABLE;
          hold_if_id  = HOLD_ENABLE;
          flush_id_ex = 1'b1;
        end else if (bus.bus_wait_i) begin
          // Fetch not ready: hold PC and pass a bubble into ID.
          hold_pc     = HOLD_ENABLE;
          flush_if_id = 1'b1;
        end
      end

      PIPE_ST_REDIR: begin
        // The instruction fetched in the jump cycle is stale; squash it.
        flush_if_id = 1'b1;
        state_d     = PIPE_ST_RUN;
      end

      PIPE_ST_DIV: begin
        hold_pc    = HOLD_ENABLE;
        hold_if_id = HOLD_ENABLE;
        hold_ex    = HOLD_ENABLE;
        cnt_d      = cnt_q - CNT_ONE;
        // Final hold cycle is the one whose decrement brings the counter to 0.
        if (cnt_q <= CNT_ONE) begin
          cnt_d    = '0;
          div_done = 1'b1;
          state_d  = PIPE_ST_RUN;
        end
      end

      default: begin
        state_d = PIPE_ST_RUN;
      end
    endcase

    if (arst) begin
      hold_pc     = HOLD_DISABLE;
      hold_if_id  = HOLD_DISABLE;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      hold_ex     = HOLD_DISABLE;
      jump_ena    = JUMP_DISABLE;
      jump_addr   = '0;
      div_done    = 1'b0;
    end
  end

  assign bus.hold_pc_o     = hold_pc;
  assign bus.hold_if_id_o  = hold_if_id;
  assign bus.flush_if_id_o = flush_if_id;
  assign bus.flush_id_ex_o = flush_id_ex;
  assign bus.hold_ex_o     = hold_ex;
  assign bus.jump_ena_o    = jump_ena;
  assign bus.jump_addr_o   = jump_addr;
  assign bus.div_done_o    = div_done;
  assign bus.state_dbg     = state_q;

`ifdef PIPE_STALL_CNT_EN
  // Cycle counters for PC holds and IF/ID squashes; wrap naturally.
  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      stall_cycles_o <= '0;
      flush_cycles_o <= '0;
    end else begin
      if (hold_pc)     stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_if_id) flush_cycles_o <= flush_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: drivers push a hand-computed expected
// output vector per cycle; a monitor pops and compares on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int OBS_W = 41;

  typedef struct packed {
    logic        hold_pc;
    logic        hold_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        hold_ex;
    logic        jump_ena;
    logic        div_done;
    logic [31:0] jump_addr;
    logic [1:0]  state;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk_100MHz = 1'b0;
  logic arst       = 1'b1;
  always #5 clk_100MHz = ~clk_100MHz;

  pipe_ctrl_if bus ();

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
`endif

  pipe_ctrl #(
    .DIV_CYCLES (8),
    .CNT_W      (8)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .arst       (arst),
    .bus        (bus)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cycles_o (stall_cycles),
    .flush_cycles_o (flush_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  string            name_q[$];
  int               checks = 0;
  int               errors = 0;

  function automatic obs_t mk(input logic hpc, input logic hif, input logic fif,
                              input logic fex, input logic hex, input logic je,
                              input logic dd, input logic [31:0] addr,
                              input pipe_st_e st);
    obs_t o;
    o.hold_pc     = hpc;
    o.hold_if_id  = hif;
    o.flush_if_id = fif;
    o.flush_id_ex = fex;
    o.hold_ex     = hex;
    o.jump_ena    = je;
    o.div_done    = dd;
    o.jump_addr   = addr;
    o.state       = st;
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string name, input logic rst_v, input logic jr,
                      input logic [31:0] ja, input logic ds, input logic ld,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic re1, input logic re2,
                      input logic bw, input obs_t e);
    @(posedge clk_100MHz);
    #1;
    arst             = rst_v;
    bus.jump_req_i   = jr;
    bus.jump_addr_i  = ja;
    bus.div_start_i  = ds;
    bus.ex_is_load_i = ld;
    bus.ex_rd_i      = rd;
    bus.id_rs1_i     = rs1;
    bus.id_rs2_i     = rs2;
    bus.id_rs1_re_i  = re1;
    bus.id_rs2_re_i  = re2;
    bus.bus_wait_i   = bw;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic idle(input string name, input logic rst_v, input obs_t e);
    step(name, rst_v, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_100MHz) begin
    obs_t  act;
    obs_t  exp_v;
    string nm;
    if (exp_q.size() > 0) begin
      act = {bus.hold_pc_o, bus.hold_if_id_o, bus.flush_if_id_o, bus.flush_id_ex_o,
             bus.hold_ex_o, bus.jump_ena_o, bus.div_done_o, bus.jump_addr_o,
             bus.state_dbg};
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
      end
      checks++;
      if (bus.hold_if_id_o && bus.flush_if_id_o) begin
        errors++;
        $display("FAIL %s_ifid_excl actual hold=1 flush=1 required not both", nm);
      end
      checks++;
      if ((bus.state_dbg == PIPE_ST_REDIR) && bus.jump_req_i) begin
        errors++;
        $display("FAIL %s_redir_jump actual jump_req_i=1 in REDIR required 0", nm);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.jump_req_i   = 1'b0;
    bus.jump_addr_i  = '0;
    bus.div_start_i  = 1'b0;
    bus.ex_is_load_i = 1'b0;
    bus.ex_rd_i      = '0;
    bus.id_rs1_i     = '0;
    bus.id_rs2_i     = '0;
    bus.id_rs1_re_i  = 1'b0;
    bus.id_rs2_re_i  = 1'b0;
    bus.bus_wait_i   = 1'b0;

    // Reset and jump sequence
    idle("reset", 1'b1, mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));
    idle("post_reset", 1'b0, mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));
    step("jump_n", 0, 1, 32'h100, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(0,0,1,1,0,1,0, 32'h100, PIPE_ST_RUN));
    idle("jump_n1", 1'b0, mk(0,0,1,0,0,0,0, 32'h100, PIPE_ST_REDIR));
    idle("jump_n2", 1'b0, mk(0,0,0,0,0,0,0, 32'h100, PIPE_ST_RUN));

    // Load-use detection
    step("lu_rs2", 0, 0, 32'h0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0,
         mk(1,1,0,1,0,0,0, 32'h100, PIPE_ST_RUN));
    step("lu_rd0", 0, 0, 32'h0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0,
         mk(0,0,0,0,0,0,0, 32'h100, PIPE_ST_RUN));
    step("lu_rs1", 0, 0, 32'h0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 1, 0,
         mk(1,1,0,1,0,0,0, 32'h100, PIPE_ST_RUN));
    step("lu_rs1_nore", 0, 0, 32'h0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0,
         mk(0,0,0,0,0,0,0, 32'h100, PIPE_ST_RUN));
    step("lu_not_load", 0, 0, 32'h0, 0, 0, 5'd5, 5'd0, 5'd5, 0, 1, 0,
         mk(0,0,0,0,0,0,0, 32'h100, PIPE_ST_RUN));
    step("bus_wait", 0, 0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1,
         mk(1,0,1,0,0,0,0, 32'h100, PIPE_ST_RUN));
    step("bw_and_lu", 0, 0, 32'h0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1,
         mk(1,1,0,1,0,0,0, 32'h100, PIPE_ST_RUN));

    // Divide: 8 hold cycles, done on the last; jump/bus_wait/load-use ignored
    step("div_n", 0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(1,1,0,0,1,0,0, 32'h100, PIPE_ST_RUN));
    for (int i = 1; i <= 7; i++) begin
      step($sformatf("div_n%0d", i), 0, (i == 3), 32'h200, 0, (i == 5),
           5'd5, 5'd0, 5'd5, 0, (i == 5), (i == 4),
           mk(1,1,0,0,1,0,(i == 7), 32'h100, PIPE_ST_DIV));
    end
    idle("div_end", 1'b0, mk(0,0,0,0,0,0,0, 32'h100, PIPE_ST_RUN));

    // Jump and divide together: jump wins
    step("prio_jump", 0, 1, 32'h300, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(0,0,1,1,0,1,0, 32'h300, PIPE_ST_RUN));
    idle("prio_redir", 1'b0, mk(0,0,1,0,0,0,0, 32'h300, PIPE_ST_REDIR));
    idle("prio_run", 1'b0, mk(0,0,0,0,0,0,0, 32'h300, PIPE_ST_RUN));

    // Reset while dividing (counter at 5)
    step("rdiv_start", 0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(1,1,0,0,1,0,0, 32'h300, PIPE_ST_RUN));
    idle("rdiv_c7", 1'b0, mk(1,1,0,0,1,0,0, 32'h300, PIPE_ST_DIV));
    idle("rdiv_c6", 1'b0, mk(1,1,0,0,1,0,0, 32'h300, PIPE_ST_DIV));
    idle("rdiv_reset", 1'b1, mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));
    for (int i = 0; i < 3; i++) begin
      idle("rdiv_after", 1'b0, mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));
    end

    // Reset while in REDIR
    step("rredir_jump", 0, 1, 32'h40, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(0,0,1,1,0,1,0, 32'h40, PIPE_ST_RUN));
    step("rredir_reset", 1, 1, 32'h44, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));
    idle("rredir_after", 1'b0, mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));

    // Three load-use stalls plus one jump
    idle("cnt_reset", 1'b1, mk(0,0,0,0,0,0,0, 32'h0, PIPE_ST_RUN));
    for (int i = 0; i < 3; i++) begin
      step("cnt_lu", 0, 0, 32'h0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0,
           mk(1,1,0,1,0,0,0, 32'h0, PIPE_ST_RUN));
    end
    step("cnt_jump", 0, 1, 32'h80, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
         mk(0,0,1,1,0,1,0, 32'h80, PIPE_ST_RUN));
    idle("cnt_redir", 1'b0, mk(0,0,1,0,0,0,0, 32'h80, PIPE_ST_REDIR));
    idle("cnt_idle", 1'b0, mk(0,0,0,0,0,0,0, 32'h80, PIPE_ST_RUN));

    // Drain the scoreboard (bounded)
    repeat (3) @(negedge clk_100MHz);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

`ifdef PIPE_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL stall_cycles actual=%0d required=3", stall_cycles);
    end
    checks++;
    if (flush_cycles !== 32'd2) begin
      errors++;
      $display("FAIL flush_cycles actual=%0d required=2", flush_cycles);
    end
`endif

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
